// File: rtl/cae_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cae_pkg : shared types, default widths and the result rounding helper |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package cae_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BIAS_WIDTH = 16;
  localparam int ACC_WIDTH  = 32;

  typedef enum logic {
    CONV = 1'b0,
    FC   = 1'b1
  } layer_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Treats x as an in_w-bit signed value, rounds half-up on the shift, then clamps to out_w bits.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] x,
                                                   input int in_w,
                                                   input logic [4:0] shift,
                                                   input int out_w);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    v  = x <<< (64 - in_w);
    v  = v >>> (64 - in_w);
    if (shift != 5'd0) begin
      v = (v + (64'sd1 <<< (shift - 5'd1))) >>> shift;
    end
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cae_dot_lane.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cae_dot_lane : combinational VEC-wide signed dot product              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cae_dot_lane #(
  parameter int  DATA_WIDTH = 8,
  parameter int  VEC        = 9,
  localparam int OUT_WIDTH  = 2 * DATA_WIDTH + $clog2(VEC)
) (
  input  logic [VEC-1:0][DATA_WIDTH-1:0] a_i,
  input  logic [VEC-1:0][DATA_WIDTH-1:0] b_i,
  output logic signed [OUT_WIDTH-1:0]    dot_o
);
  import cae_pkg::*;

  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    dot_o = '0;
    prod  = '0;
    for (int v = 0; v < VEC; v++) begin
      prod  = $signed(a_i[v]) * $signed(b_i[v]);
      dot_o = dot_o + OUT_WIDTH'(prod);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cae_layer_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cae_layer_engine : LANES-wide MAC with bias, ReLU, round and saturate |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cae_layer_engine #(
  parameter int  DATA_WIDTH = cae_pkg::DATA_WIDTH,
  parameter int  BIAS_WIDTH = cae_pkg::BIAS_WIDTH,
  parameter int  ACC_WIDTH  = cae_pkg::ACC_WIDTH,
  parameter int  VEC        = 9,
  parameter int  LANES      = 8,
  parameter int  MAX_BEATS  = 64,
  parameter int  MAX_WIN    = 1024,
  localparam int BEAT_W     = $clog2(MAX_BEATS + 1),
  localparam int WIN_W      = $clog2(MAX_WIN + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n,
  input  logic                                    cfg_valid_i,
  output logic                                    cfg_ready_o,
  input  cae_pkg::layer_e                         cfg_mode_i,
  input  logic [BEAT_W-1:0]                       cfg_beats_i,
  input  logic [WIN_W-1:0]                        cfg_windows_i,
  input  logic [4:0]                              cfg_shift_i,
  input  logic                                    cfg_relu_i,
  input  logic                                    in_valid_i,
  output logic                                    in_ready_o,
  input  logic [VEC-1:0][DATA_WIDTH-1:0]          data_i,
  input  logic [LANES-1:0][VEC-1:0][DATA_WIDTH-1:0] weight_i,
  input  logic [LANES-1:0][BIAS_WIDTH-1:0]        bias_i,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]        data_o,
  output logic                                    out_last_o
);
  import cae_pkg::*;

  localparam int DOT_W = 2 * DATA_WIDTH + $clog2(VEC);

  state_e                                state_q, state_d;
  layer_e                                mode_q;
  logic [BEAT_W-1:0]                     beats_q, beat_cnt_q;
  logic [WIN_W-1:0]                      windows_q, win_cnt_q;
  logic [4:0]                            shift_q;
  logic                                  relu_q;
  logic                                  last_q;
  logic [LANES-1:0][ACC_WIDTH-1:0]       acc_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]      data_q;

  logic [LANES-1:0][ACC_WIDTH-1:0]       acc_sum;
  logic [LANES-1:0][DATA_WIDTH-1:0]      res;
  logic                                  last_beat;
  logic [BEAT_W-1:0]                     beats_eff;
  logic [WIN_W-1:0]                      win_eff;

  assign last_beat = (beat_cnt_q == beats_q - BEAT_W'(1));
  assign beats_eff = (cfg_beats_i == '0) ? BEAT_W'(1) : cfg_beats_i;
  assign win_eff   = (cfg_mode_i == FC || cfg_windows_i == '0) ? WIN_W'(1) : cfg_windows_i;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [DOT_W-1:0]     dot;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] relu_v;

    cae_dot_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .VEC       (VEC)
    ) u_dot (
      .a_i  (data_i),
      .b_i  (weight_i[l]),
      .dot_o(dot)
    );

    // Bias joins only on the opening beat of each window.
    assign sum = acc_q[l] + ACC_WIDTH'(dot)
               + ((beat_cnt_q == '0) ? ACC_WIDTH'($signed(bias_i[l])) : '0);
    assign relu_v     = (relu_q && sum < 0) ? '0 : sum;
    assign acc_sum[l] = sum;
    assign res[l]     = DATA_WIDTH'(sat_round(64'(relu_v), ACC_WIDTH, shift_q, DATA_WIDTH));
  end

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready_o = 1'b1;
        if (in_valid_i && last_beat) state_d = HOLD;
      end
      HOLD: begin
        out_valid_o = 1'b1;
        out_last_o  = last_q;
        if (out_ready_i) state_d = last_q ? IDLE : ACCUM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= CONV;
      beats_q    <= '0;
      windows_q  <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      beat_cnt_q <= '0;
      win_cnt_q  <= '0;
      acc_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid_i) begin
            mode_q     <= cfg_mode_i;
            beats_q    <= beats_eff;
            windows_q  <= win_eff;
            shift_q    <= cfg_shift_i;
            relu_q     <= cfg_relu_i;
            beat_cnt_q <= '0;
            win_cnt_q  <= '0;
            acc_q      <= '0;
          end
        end
        ACCUM: begin
          if (in_valid_i) begin
            acc_q      <= acc_sum;
            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
            if (last_beat) begin
              data_q <= res;
              last_q <= (mode_q == FC) || (win_cnt_q == windows_q - WIN_W'(1));
            end
          end
        end
        HOLD: begin
          if (out_ready_i && !last_q) begin
            acc_q      <= '0;
            beat_cnt_q <= '0;
            win_cnt_q  <= win_cnt_q + WIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: tb/tb_cae_layer_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cae_layer_engine : directed vector bench for cae_layer_engine      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_cae_layer_engine;
  import cae_pkg::*;

  localparam int DW    = 8;
  localparam int BW    = 16;
  localparam int VEC   = 9;
  localparam int LANES = 8;
  localparam int CBW   = $clog2(64 + 1);
  localparam int CWW   = $clog2(1024 + 1);

  logic                               clk_i = 1'b0;
  logic                               rst_n = 1'b0;
  logic                               cfg_valid_i = 1'b0;
  logic                               cfg_ready_o;
  layer_e                             cfg_mode_i = CONV;
  logic [CBW-1:0]                     cfg_beats_i = '0;
  logic [CWW-1:0]                     cfg_windows_i = '0;
  logic [4:0]                         cfg_shift_i = '0;
  logic                               cfg_relu_i = 1'b0;
  logic                               in_valid_i = 1'b0;
  logic                               in_ready_o;
  logic [VEC-1:0][DW-1:0]             data_i = '0;
  logic [LANES-1:0][VEC-1:0][DW-1:0]  weight_i = '0;
  logic [LANES-1:0][BW-1:0]           bias_i = '0;
  logic                               out_valid_o;
  logic                               out_ready_i = 1'b0;
  logic [LANES-1:0][DW-1:0]           data_o;
  logic                               out_last_o;

  int errors = 0;
  int checks = 0;

  cae_layer_engine dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_mode_i   (cfg_mode_i),
    .cfg_beats_i  (cfg_beats_i),
    .cfg_windows_i(cfg_windows_i),
    .cfg_shift_i  (cfg_shift_i),
    .cfg_relu_i   (cfg_relu_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .data_i       (data_i),
    .weight_i     (weight_i),
    .bias_i       (bias_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .data_o       (data_o),
    .out_last_o   (out_last_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [VEC*DW-1:0]   data;
    int                  wmul;
    int                  wadd;
    int                  bmul;
    int                  badd;
    int                  beats;
    int                  shift;
    logic                relu;
    logic [LANES*DW-1:0] exp;
  } vec_t;

  vec_t tbl [9];

  function automatic logic [VEC*DW-1:0] all_d(input int x);
    logic [VEC*DW-1:0] r;
    for (int v = 0; v < VEC; v++) r[v*DW +: DW] = DW'(x);
    return r;
  endfunction

  function automatic logic [VEC*DW-1:0] d0(input int x);
    logic [VEC*DW-1:0] r;
    r = '0;
    r[DW-1:0] = DW'(x);
    return r;
  endfunction

  function automatic logic [LANES*DW-1:0] ex(input int a, b, c, d, e, f, g, h);
    return {DW'(h), DW'(g), DW'(f), DW'(e), DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, got 0 expected 1", nm);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic [VEC*DW-1:0] d, input int wmul, wadd, bmul, badd);
    data_i = d;
    for (int l = 0; l < LANES; l++) begin
      bias_i[l] = BW'(bmul * l + badd);
      for (int v = 0; v < VEC; v++) weight_i[l][v] = DW'(wmul * l + wadd);
    end
  endtask

  task automatic do_cfg(input layer_e mode, input int beats, windows, shift, input logic relu);
    int n;
    n = 0;
    cfg_mode_i    = mode;
    cfg_beats_i   = CBW'(beats);
    cfg_windows_i = CWW'(windows);
    cfg_shift_i   = 5'(shift);
    cfg_relu_i    = relu;
    cfg_valid_i   = 1'b1;
    while (!cfg_ready_o && n < 50) begin cyc(); n++; end
    if (!cfg_ready_o) timeout("cfg_wait");
    cyc();
    cfg_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [VEC*DW-1:0] d, input int wmul, wadd, bmul, badd);
    int n;
    n = 0;
    set_in(d, wmul, wadd, bmul, badd);
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 50) begin cyc(); n++; end
    if (!in_ready_o) timeout("in_wait");
    cyc();
    in_valid_i = 1'b0;
  endtask

  task automatic get_out(input string nm, input logic [LANES*DW-1:0] exp, input logic last);
    int n;
    n = 0;
    out_ready_i = 1'b1;
    while (!out_valid_o && n < 50) begin cyc(); n++; end
    if (!out_valid_o) begin
      timeout({nm, "_valid"});
    end else begin
      chk(nm, data_o, exp);
      chk({nm, "_last"}, out_last_o, last);
    end
    cyc();
    out_ready_i = 1'b0;
  endtask

  initial begin
    logic [LANES*DW-1:0] e;

    tbl[0] = '{all_d(1),   1,   0,   0,    5, 2, 0, 1'b0, ex(5, 23, 41, 59, 77, 95, 113, 127)};
    tbl[1] = '{d0(10),     0, -13,   0,    0, 1, 2, 1'b0, ex(-32, -32, -32, -32, -32, -32, -32, -32)};
    tbl[2] = '{d0(10),     0, -13,   0,    0, 1, 2, 1'b1, ex(0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[3] = '{d0(127),    0, 127,   0,    0, 1, 0, 1'b0, ex(127, 127, 127, 127, 127, 127, 127, 127)};
    tbl[4] = '{all_d(1),  -1,   0,   0,    0, 1, 4, 1'b0, ex(0, -1, -1, -2, -2, -3, -3, -4)};
    tbl[5] = '{all_d(0),   0,   0, 100,    0, 1, 3, 1'b0, ex(0, 13, 25, 38, 50, 63, 75, 88)};
    tbl[6] = '{all_d(0),   0,   0, -10,    0, 1, 1, 1'b0, ex(0, -5, -10, -15, -20, -25, -30, -35)};
    tbl[7] = '{d0(-128),   0, 127,   0, -100, 1, 0, 1'b0, ex(-128, -128, -128, -128, -128, -128, -128, -128)};
    tbl[8] = '{all_d(1),   1,  -4,   0,    0, 1, 1, 1'b1, ex(0, 0, 0, 0, 0, 5, 9, 14)};

    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();

    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_cfg_ready", cfg_ready_o, 1);
    chk("rst_in_ready", in_ready_o, 0);
    chk("rst_out_last", out_last_o, 0);

    // Beats offered while idle must not be taken.
    set_in(all_d(3), 1, 0, 0, 7);
    in_valid_i = 1'b1;
    repeat (3) cyc();
    in_valid_i = 1'b0;
    chk("idle_in_ready", in_ready_o, 0);
    chk("idle_out_valid", out_valid_o, 0);

    for (int i = 0; i < 9; i++) begin
      do_cfg(FC, tbl[i].beats, 3, tbl[i].shift, tbl[i].relu);
      for (int b = 0; b < tbl[i].beats; b++)
        send_beat(tbl[i].data, tbl[i].wmul, tbl[i].wadd, tbl[i].bmul, tbl[i].badd);
      get_out($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
      chk($sformatf("vec%0d_idle", i), cfg_ready_o, 1);
    end

    // CONV: 3 windows x 4 beats, bias on later beats must be ignored.
    e = ex(2, 38, 74, 110, 127, 127, 127, 127);
    do_cfg(CONV, 4, 3, 0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      for (int b = 0; b < 4; b++) send_beat(all_d(1), 1, 0, 0, (b == 0) ? 2 : 50);
      get_out($sformatf("conv_w%0d", w), e, (w == 2));
    end
    chk("conv_idle", cfg_ready_o, 1);

    // Back-pressure with in_valid pulses during HOLD.
    e = ex(3, 12, 21, 30, 39, 48, 57, 66);
    do_cfg(CONV, 1, 2, 0, 1'b0);
    send_beat(all_d(1), 1, 0, 0, 3);
    chk("bp_latency", out_valid_o, 1);
    for (int k = 0; k < 5; k++) begin
      set_in(all_d(5), 3, 1, 0, 9);
      in_valid_i = (k % 2 == 0);
      chk($sformatf("bp_data%0d", k), data_o, e);
      chk($sformatf("bp_in_ready%0d", k), in_ready_o, 0);
      chk($sformatf("bp_valid%0d", k), out_valid_o, 1);
      cyc();
    end
    in_valid_i = 1'b0;
    get_out("bp_w0", e, 1'b0);
    send_beat(all_d(1), 1, 0, 0, 3);
    get_out("bp_w1", e, 1'b1);

    // Degenerate config: beats=0, windows=0.
    do_cfg(CONV, 0, 0, 0, 1'b0);
    send_beat(all_d(2), 1, 0, 0, 1);
    get_out("degen", ex(1, 19, 37, 55, 73, 91, 109, 127), 1'b1);
    chk("degen_idle", cfg_ready_o, 1);

    // Asynchronous reset in the middle of accumulation.
    do_cfg(FC, 5, 1, 0, 1'b0);
    for (int b = 0; b < 3; b++) send_beat(all_d(4), 2, 1, 0, 11);
    chk("mid_in_ready", in_ready_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_data", data_o, 0);
    chk("mid_rst_cfg_ready", cfg_ready_o, 1);
    chk("mid_rst_in_ready", in_ready_o, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    do_cfg(FC, 1, 1, 0, 1'b0);
    send_beat(all_d(1), 0, 1, 0, 0);
    get_out("post_rst", ex(9, 9, 9, 9, 9, 9, 9, 9), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cae_layer_engine.md
# cae_layer_engine

Parametrised successor to the fixed-size CAE compute core. Runs a LANES-wide multiply-accumulate over a configurable number of input beats, adds per-lane bias, applies optional ReLU, a rounding right-shift and saturation, then emits one output vector. It supports CONV mode (repeated windows under one configuration) and FC mode (single vector), with valid/ready handshakes on configuration, input and output.

## Interface
- DATA_WIDTH, 8, signed width of data, weight and output elements
- BIAS_WIDTH, 16, signed bias width
- ACC_WIDTH, 32, accumulator width; must be ≥ 2·DATA_WIDTH + $clog2(VEC·MAX_BEATS) + 1
- VEC, 9, products per lane per beat (3×3 window)
- LANES, 8, parallel output channels
- MAX_BEATS, 64, maximum beats per output
- MAX_WIN, 1024, maximum windows per CONV configuration
- clk_i  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous and active-low
- cfg_valid_i / cfg_ready_o  in/out  1  configuration handshake
- cfg_mode_i  in  layer_e  CONV=0 or FC=1
- cfg_beats_i  in  $clog2(MAX_BEATS+1)  beats per output; 0 is treated as 1
- cfg_windows_i  in  $clog2(MAX_WIN+1)  output vectors in CONV; ignored in FC (always 1); 0 is treated as 1
- cfg_shift_i  in  5  right-shift amount
- cfg_relu_i  in  1  enable ReLU
- in_valid_i / in_ready_o  in/out  1  input beat handshake
- data_i  in  [VEC][DATA_WIDTH]  shared activations, signed
- weight_i  in  [LANES][VEC][DATA_WIDTH]  per-lane weights, signed
- bias_i  in  [LANES][BIAS_WIDTH]  sampled on the first beat of each window only
- out_valid_o / out_ready_i  out/in  1  output handshake
- data_o  out  [LANES][DATA_WIDTH]  result vector, signed
- out_last_o  out  1  marks the final vector of the configuration

## Operation
- States: IDLE, ACCUM, HOLD.
- **IDLE**
  - cfg_ready_o=1.
  - cfg_valid_i captures all cfg fields and clears the beat counter, window counter and accumulators, then moves to ACCUM.
- **ACCUM**
  - in_ready_o=1.
  - Each accepted beat: acc[l] += Σv data_i[v]·weight_i[l][v], full-precision signed.
  - The first beat of each window also adds sign-extended bias_i[l].
  - On the beat where beat_cnt == beats−1, the result is registered into data_o, out_valid_o is set, and the state moves to HOLD.
- **Result pipeline, per lane**
  - Input is the final accumulator value, including the current beat.
  - ReLU (if enabled): negative values become 0.
  - If shift>0, add 1<<(shift−1), then arithmetic shift right by shift.
  - Saturate to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- **HOLD**
  - in_ready_o=0 and cfg_ready_o=0.
  - data_o, out_last_o and out_valid_o stay stable until out_ready_i.
  - On the output handshake:
    - CONV with windows remaining: clear the accumulators and beat counter, increment the window counter, return to ACCUM.
    - Otherwise (FC, or the last CONV window): go to IDLE.
- out_last_o=1 exactly when the held vector is the final one (FC always; CONV when win_cnt == windows−1).
- The accumulator wraps in two's complement; the ACC_WIDTH rule above guarantees this never happens for legal inputs.

## Timing
- Reset values: all state registers to IDLE, all counters and accumulators 0, data_o all 0, out_valid_o=0, out_last_o=0, in_ready_o=0, cfg_ready_o=1 once reset is released.
- Asserting rst_n low mid-operation aborts immediately; any partial accumulation and any held output are discarded.
- Latency: last beat accepted at cycle t gives out_valid_o=1 at t+1.
- Throughput: beats+1 cycles per window with no back-pressure. Input and output never overlap.
- in_valid_i is ignored outside ACCUM; cfg_valid_i is ignored outside IDLE.
- Ready signals are functions of state only and do not depend combinationally on the corresponding valid.
- beats=1: every beat produces an output, and bias is added on that same beat.

## Structure
- Package `cae_pkg` holds:
  - `layer_e` (CONV=0, FC=1)
  - `state_e`
  - a `sat_round` function (parameters: input width, shift, output width)
  - the default widths DATA_WIDTH, BIAS_WIDTH and ACC_WIDTH.
- Sub-module `cae_dot_lane`: combinational VEC-wide signed dot product. It is instantiated LANES times, and its output width is 2·DATA_WIDTH+$clog2(VEC).
- The top holds the FSM, counters, accumulators and the output register.

## Test plan
- **Reset:** assert rst_n low while in ACCUM after 3 beats → next cycle out_valid_o=0, data_o=0, cfg_ready_o=1; a new FC cfg then gives a clean result.
- **FC basic:** beats=2, shift=0, relu=0, data all 1, weights lane l = l, bias 5 → data_o[l] = 18·l + 5, saturated to 127 for l≥7; out_last_o=1; return to IDLE after the handshake.
- **Rounding, saturation and ReLU:** FC, beats=1, single product 10·(−13)=−130, bias 0:
  - shift=2, relu=0 → −32 (−130+2 = −128, shifted right by 2)
  - relu=1 → 0
  - product 127·127, shift 0 → 127
- **CONV windows:** windows=3, beats=4 → three outputs. Bias is added once per window, and the accumulator is cleared between windows (identical stimulus per window gives identical outputs). out_last_o is set only on the third output.
- **Back-pressure:** hold out_ready_i=0 for 5 cycles → data_o stable, in_ready_o=0, and in_valid_i pulses are ignored (the next window's result is unaffected).
- **Degenerate config:** beats=0, windows=0 → behaves as beats=1, windows=1.
